memory_unit: RTL and testbench

Single-port synchronous RAM for the A09 processor: 256 words × 16 bits, shared by instruction fetch and data load/store. Read and write are performed on the falling edge of `Clk`, so an address driven just after a rising edge yields data by the following falling edge. Contents are preloaded at power-up with the boot program starting at reset vector 0x05.

---
 rtl/memory_unit_if.sv | 36 +++
 rtl/memory_unit.sv | 74 +++++++
 tb/tb_memory_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/memory_unit_if.sv
// -----------------------------------------------------------------------------
// memory_unit_if
//   Bus bundle between an A09 memory client (master) and memory_unit (slave).
//
//   DIn      master -> slave  write data
//   Address  master -> slave  word address
//   Write_EN master -> slave  active-low write enable (0 = write, 1 = read)
//   Mem_En   master -> slave  active-low memory enable (0 = access, 1 = idle)
//   DOut     slave  -> master registered read / write-through data
// -----------------------------------------------------------------------------
interface memory_unit_if #(
    parameter int Data_WIDTH    = 16,
    parameter int Address_WIDTH = 8
);
    logic [Data_WIDTH-1:0]    DIn;
    logic [Address_WIDTH-1:0] Address;
    logic                     Write_EN;
    logic                     Mem_En;
    logic [Data_WIDTH-1:0]    DOut;

    modport master (
        output DIn,
        output Address,
        output Write_EN,
        output Mem_En,
        input  DOut
    );

    modport slave (
        input  DIn,
        input  Address,
        input  Write_EN,
        input  Mem_En,
        output DOut
    );
endinterface : memory_unit_if

// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
//   Single-port synchronous RAM shared by A09 instruction fetch and data
//   load/store. 2^Address_WIDTH words of Data_WIDTH bits. Every access happens
//   on the falling edge of Clk, so an address launched just after a rising
//   edge returns data half a cycle later.
//
//   Ports
//     Clk    in   system clock; memory acts on the falling edge only
//     Reset  in   asynchronous active-high; clears DOut, keeps array contents,
//                 and blocks reads/writes while high
//     bus    slave modport of memory_unit_if (DIn, Address, Write_EN, Mem_En
//                 in; DOut out)
//
//   Power-up image: boot program at reset vector 0x05
//     0x05 = 0x9101  LDI R1,0x01
//     0x06 = 0x9201  LDI R2,0x01
//     0x07 = 0x9308  LDI R3,0x08
//     all other words 0
// -----------------------------------------------------------------------------
module memory_unit #(
    parameter int Data_WIDTH    = 16,
    parameter int Address_WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    memory_unit_if.slave  bus
);

    localparam int DEPTH = 1 << Address_WIDTH;

    // Boot image is a declaration initialiser so it lands in the RAM's
    // configuration contents; Reset never touches the array.
    logic [Data_WIDTH-1:0] r_mem [DEPTH] = '{
        5       : Data_WIDTH'(16'h9101),
        6       : Data_WIDTH'(16'h9201),
        7       : Data_WIDTH'(16'h9308),
        default : '0
    };

    logic [Data_WIDTH-1:0] r_dout;

    logic w_access;
    logic w_write;

    // Reset is sampled as a level at the falling edge: an access landing on
    // an edge while Reset is high is dropped entirely.
    assign w_access = ~bus.Mem_En & ~Reset;
    assign w_write  = w_access & ~bus.Write_EN;

    // Array port kept free of the asynchronous reset so it maps onto block RAM.
    always_ff @(negedge Clk) begin
        if (w_write) begin
            r_mem[bus.Address] <= bus.DIn;
        end
    end

    // Output register: read data on a read, DIn on a write (write-through),
    // hold when idle. Asynchronous clear makes DOut drop to 0 immediately.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dout <= '0;
        end else if (!bus.Mem_En) begin
            if (bus.Write_EN) begin
                r_dout <= r_mem[bus.Address];
            end else begin
                r_dout <= bus.DIn;
            end
        end
    end

    assign bus.DOut = r_dout;

endmodule : memory_unit

// File: tb/tb_memory_unit.sv
`timescale 1ns/1ps
module tb_memory_unit;

    logic clk;
    logic rst;

    memory_unit_if #(.Data_WIDTH(16), .Address_WIDTH(8)) bus ();

    memory_unit #(.Data_WIDTH(16), .Address_WIDTH(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // 20 ns period: rising edges at 10, 30, ...; falling edges at 20, 40, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp;
    int n_bad;
    logic [15:0] prev_exp;

    typedef struct {
        logic        mem_en;   // active low
        logic        we;       // active low
        logic [7:0]  addr;
        logic [15:0] din;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: DOut=0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // One bus cycle: launch just after the rising edge (checking DOut did not
    // move on that edge), then sample 2 ns after the falling edge.
    task automatic do_cycle(input logic en, input logic we, input logic [7:0] a,
                            input logic [15:0] d, input logic [15:0] exp, input string name);
        @(posedge clk);
        #1;
        check($sformatf("%s_hold_at_rise", name), bus.DOut, prev_exp);
        bus.Mem_En   = en;
        bus.Write_EN = we;
        bus.Address  = a;
        bus.DIn      = d;
        @(negedge clk);
        #2;
        check(name, bus.DOut, exp);
        $display("cycle %-14s en=%b we=%b addr=0x%02h din=0x%04h -> DOut=0x%04h (exp 0x%04h)",
                 name, en, we, a, d, bus.DOut, exp);
        prev_exp = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        prev_exp = 16'h0000;

        vecs[0]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 16'h9101, "rd_05_boot"};
        vecs[1]  = '{1'b0, 1'b1, 8'h06, 16'h0000, 16'h9201, "rd_06_boot"};
        vecs[2]  = '{1'b0, 1'b1, 8'h07, 16'h0000, 16'h9308, "rd_07_boot"};
        vecs[3]  = '{1'b0, 1'b0, 8'h0A, 16'h0666, 16'h0666, "wr_0A_thru"};
        vecs[4]  = '{1'b0, 1'b1, 8'h0A, 16'h0000, 16'h0666, "rd_0A_raw"};
        vecs[5]  = '{1'b1, 1'b0, 8'h05, 16'hFFFF, 16'h0666, "idle_wr_05"};
        vecs[6]  = '{1'b0, 1'b1, 8'h05, 16'h0000, 16'h9101, "rd_05_kept"};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'h0000, "rd_FF_blank"};
        vecs[8]  = '{1'b0, 1'b0, 8'hFF, 16'hABCD, 16'hABCD, "wr_FF_thru"};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000, "rd_00_blank"};
        vecs[10] = '{1'b0, 1'b1, 8'hFF, 16'h0000, 16'hABCD, "rd_FF_new"};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 16'h1234, 16'h1234, "wr_00_thru"};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h1234, "rd_00_new"};
        vecs[13] = '{1'b1, 1'b1, 8'h07, 16'h0000, 16'h1234, "idle_rd_07"};
        vecs[14] = '{1'b0, 1'b1, 8'h07, 16'h0000, 16'h9308, "rd_07_again"};
        vecs[15] = '{1'b0, 1'b1, 8'h0A, 16'h0000, 16'h0666, "rd_0A_again"};

        // Power-up with reset held and bus idle.
        rst          = 1'b1;
        bus.Mem_En   = 1'b1;
        bus.Write_EN = 1'b1;
        bus.Address  = 8'h00;
        bus.DIn      = 16'h0000;
        #5;
        check("reset_state", bus.DOut, 16'h0000);
        #7;                      // t = 12, between edges
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            do_cycle(vecs[i].mem_en, vecs[i].we, vecs[i].addr, vecs[i].din,
                     vecs[i].exp, vecs[i].name);
        end

        // Asynchronous reset mid-cycle right after reading a boot word.
        do_cycle(1'b0, 1'b1, 8'h05, 16'h0000, 16'h9101, "rd_05_pre_rst");
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_clear", bus.DOut, 16'h0000);
        prev_exp = 16'h0000;

        // Enabled write while reset is held must be ignored entirely.
        do_cycle(1'b0, 1'b0, 8'h0A, 16'hBEEF, 16'h0000, "wr_in_reset");
        #3;
        rst = 1'b0;
        #1;
        check("after_deassert", bus.DOut, 16'h0000);

        // Idle cycle after reset: DOut stays 0 until an enabled read.
        do_cycle(1'b1, 1'b1, 8'h05, 16'h0000, 16'h0000, "idle_post_rst");
        do_cycle(1'b0, 1'b1, 8'h0A, 16'h0000, 16'h0666, "rd_0A_retained");
        do_cycle(1'b0, 1'b1, 8'hFF, 16'h0000, 16'hABCD, "rd_FF_retained");

        // Read-after-write on back-to-back falling edges, boot word overwritten.
        do_cycle(1'b0, 1'b0, 8'h05, 16'h5A5A, 16'h5A5A, "wr_05_over");
        do_cycle(1'b0, 1'b1, 8'h05, 16'h0000, 16'h5A5A, "rd_05_over");
        do_cycle(1'b0, 1'b1, 8'h06, 16'h0000, 16'h9201, "rd_06_neighbor");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_memory_unit
